// File: rtl/uart_packet_arbiter_pkg.sv
// Shared constants and types for the UART packet arbiter: sync byte,
// source IDs, FSM states and sizing helper.
package uart_packet_arbiter_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [3:0] ID_ECG       = 4'hE;
  localparam logic [3:0] ID_TCH       = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_PAY,
    ST_CSUM
  } state_t;

  typedef enum logic {
    SRC_ECG,
    SRC_TCH
  } src_t;

  function automatic int unsigned max_bytes(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_packet_arbiter_pkt_holder.sv
// One-entry valid/ready holding buffer; ready is the registered inverse of full,
// and clear empties it when the arbiter takes the contents.
module pkt_holder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             ready,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

  assign ready = ~full;

endmodule

// File: rtl/uart_packet_arbiter.sv
// Round-robin, packet-atomic arbiter framing ECG and touch samples as
// SYNC, HDR, PAYLOAD (MSB first), CSUM onto a single UART TX byte stream.
module uart_packet_arbiter
  import uart_packet_arbiter_pkg::*;
#(
  parameter int unsigned ECG_BYTES = 6,
  parameter int unsigned TCH_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_ECG_VALID,
  input  logic [ECG_BYTES*8-1:0] i_ECG_DATA,
  output logic                   o_ECG_READY,
  input  logic                   i_TCH_VALID,
  input  logic [TCH_BYTES*8-1:0] i_TCH_DATA,
  output logic                   o_TCH_READY,
  output logic [7:0]             o_TX_DATA,
  output logic                   o_TX_VALID,
  input  logic                   i_TX_READY,
  output logic                   o_BUSY
);

  localparam int unsigned MAX_BYTES = max_bytes(ECG_BYTES, TCH_BYTES);
  localparam int unsigned SR_W      = MAX_BYTES * 8;
  localparam logic [2:0]  ECG_LAST  = 3'(ECG_BYTES - 1);
  localparam logic [2:0]  TCH_LAST  = 3'(TCH_BYTES - 1);

  logic                   ecg_full, tch_full, ecg_clear, tch_clear;
  logic [ECG_BYTES*8-1:0] ecg_q;
  logic [TCH_BYTES*8-1:0] tch_q;

  pkt_holder #(.WIDTH(ECG_BYTES * 8)) u_ecg_holder (
    .clk      (i_CLK),
    .rst      (i_RST),
    .in_valid (i_ECG_VALID),
    .in_data  (i_ECG_DATA),
    .ready    (o_ECG_READY),
    .clear    (ecg_clear),
    .full     (ecg_full),
    .data     (ecg_q)
  );

  pkt_holder #(.WIDTH(TCH_BYTES * 8)) u_tch_holder (
    .clk      (i_CLK),
    .rst      (i_RST),
    .in_valid (i_TCH_VALID),
    .in_data  (i_TCH_DATA),
    .ready    (o_TCH_READY),
    .clear    (tch_clear),
    .full     (tch_full),
    .data     (tch_q)
  );

  state_t          state, state_d;
  src_t            rr, rr_d, cur_src, cur_src_d;
  logic [3:0]      seq_ecg, seq_ecg_d, seq_tch, seq_tch_d;
  logic [2:0]      cnt, cnt_d;
  logic [SR_W-1:0] sr, sr_d;
  logic [7:0]      csum, csum_d, tx_data, tx_data_d;
  logic            tx_valid, tx_valid_d;
  logic            accept;
  logic [2:0]      last_idx;
  logic [7:0]      pay_byte;

  assign accept   = tx_valid & i_TX_READY;
  assign last_idx = (cur_src == SRC_ECG) ? ECG_LAST : TCH_LAST;
  assign pay_byte = sr[SR_W-1 -: 8];

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= ST_IDLE;
      rr       <= SRC_ECG;
      cur_src  <= SRC_ECG;
      seq_ecg  <= '0;
      seq_tch  <= '0;
      cnt      <= '0;
      sr       <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_d;
      rr       <= rr_d;
      cur_src  <= cur_src_d;
      seq_ecg  <= seq_ecg_d;
      seq_tch  <= seq_tch_d;
      cnt      <= cnt_d;
      sr       <= sr_d;
      csum     <= csum_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
    end
  end

  // The checksum accumulator is seeded with HDR at grant, so it doubles as
  // the HDR byte source in SYNC before payload bytes are folded in.
  always_comb begin
    state_d    = state;
    rr_d       = rr;
    cur_src_d  = cur_src;
    seq_ecg_d  = seq_ecg;
    seq_tch_d  = seq_tch;
    cnt_d      = cnt;
    sr_d       = sr;
    csum_d     = csum;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    ecg_clear  = 1'b0;
    tch_clear  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ecg_full && (!tch_full || rr == SRC_ECG)) begin
          ecg_clear = 1'b1;
          sr_d      = SR_W'(ecg_q) << ((MAX_BYTES - ECG_BYTES) * 8);
          csum_d    = {ID_ECG, seq_ecg};
          seq_ecg_d = seq_ecg + 4'd1;
          rr_d      = SRC_TCH;
          cur_src_d = SRC_ECG;
          state_d   = ST_SYNC;
        end else if (tch_full) begin
          tch_clear = 1'b1;
          sr_d      = SR_W'(tch_q) << ((MAX_BYTES - TCH_BYTES) * 8);
          csum_d    = {ID_TCH, seq_tch};
          seq_tch_d = seq_tch + 4'd1;
          rr_d      = SRC_ECG;
          cur_src_d = SRC_TCH;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!tx_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end else if (accept) begin
          tx_data_d = csum;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (accept) begin
          tx_data_d = pay_byte;
          csum_d    = csum ^ pay_byte;
          sr_d      = sr << 8;
          cnt_d     = '0;
          state_d   = ST_PAY;
        end
      end
      ST_PAY: begin
        if (accept) begin
          if (cnt == last_idx) begin
            tx_data_d = csum;
            state_d   = ST_CSUM;
          end else begin
            tx_data_d = pay_byte;
            csum_d    = csum ^ pay_byte;
            sr_d      = sr << 8;
            cnt_d     = cnt + 3'd1;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_TX_DATA  = tx_data;
  assign o_TX_VALID = tx_valid;
  assign o_BUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_packet_arbiter.sv
// Self-checking bench for uart_packet_arbiter: a packet-level reference model
// builds expected byte streams, compared against bytes captured from the TX port.
module tb_uart_packet_arbiter;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ecg_valid = 1'b0;
  logic [47:0] ecg_data = '0;
  logic        ecg_ready;
  logic        tch_valid = 1'b0;
  logic [15:0] tch_data = '0;
  logic        tch_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_seq_ecg = 0;
  int exp_seq_tch = 0;
  bit last_was_tch = 1'b1;  // reset state prefers ECG

  byte_q_t rx_q;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = '0;

  uart_packet_arbiter #(
    .ECG_BYTES (6),
    .TCH_BYTES (2),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_ECG_VALID (ecg_valid),
    .i_ECG_DATA  (ecg_data),
    .o_ECG_READY (ecg_ready),
    .i_TCH_VALID (tch_valid),
    .i_TCH_DATA  (tch_data),
    .o_TCH_READY (tch_ready),
    .o_TX_DATA   (tx_data),
    .o_TX_VALID  (tx_valid),
    .i_TX_READY  (tx_ready),
    .o_BUSY      (busy)
  );

  always #5 clk = ~clk;

  // Capture accepted bytes and verify a stalled byte is held unchanged.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
          n_fail++;
          $display("FAIL tx_stall_stable: valid=%b data=%h, required valid=1 data=%h",
                   tx_valid, tx_data, hold_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) rx_q.push_back(tx_data);
      hold_pending = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      hold_data    = tx_data;
    end
  end

  function automatic byte_q_t make_pkt(input bit is_ecg, input int seq, input logic [47:0] payload);
    byte_q_t    q;
    int         n;
    logic [7:0] hdr, cs, b;
    n   = is_ecg ? 6 : 2;
    hdr = {(is_ecg ? 4'hE : 4'h7), 4'(seq % 16)};
    cs  = hdr;
    q.push_back(8'hA5);
    q.push_back(hdr);
    for (int i = n - 1; i >= 0; i--) begin
      b  = payload[i*8 +: 8];
      cs = cs ^ b;
      q.push_back(b);
    end
    q.push_back(cs);
    return q;
  endfunction

  function automatic byte_q_t cat(input byte_q_t a, input byte_q_t b);
    byte_q_t r;
    r = a;
    foreach (b[i]) r.push_back(b[i]);
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic byte_q_t exp_ecg(input logic [47:0] d);
    byte_q_t p;
    p = make_pkt(1'b1, exp_seq_ecg, d);
    exp_seq_ecg  = (exp_seq_ecg + 1) % 16;
    last_was_tch = 1'b0;
    return p;
  endfunction

  function automatic byte_q_t exp_tch(input logic [15:0] d);
    byte_q_t p;
    p = make_pkt(1'b0, exp_seq_tch, {32'h0, d});
    exp_seq_tch  = (exp_seq_tch + 1) % 16;
    last_was_tch = 1'b1;
    return p;
  endfunction

  task automatic send_ecg(input logic [47:0] d);
    int t;
    t = 0;
    ecg_valid = 1'b1;
    ecg_data  = d;
    while (ecg_ready !== 1'b1 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL ecg_ready_timeout: ready=%b after %0d cycles, required 1", ecg_ready, t);
    end
    @(posedge clk); #1;
    ecg_valid = 1'b0;
  endtask

  task automatic send_tch(input logic [15:0] d);
    int t;
    t = 0;
    tch_valid = 1'b1;
    tch_data  = d;
    while (tch_ready !== 1'b1 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL tch_ready_timeout: ready=%b after %0d cycles, required 1", tch_ready, t);
    end
    @(posedge clk); #1;
    tch_valid = 1'b0;
  endtask

  // Returns at #1 after the edge on which the n-th byte is accepted.
  task automatic wait_bytes(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL byte_timeout: got %0d bytes, required %0d", rx_q.size(), n);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ecg_valid = 1'b0;
    tch_valid = 1'b0;
    tx_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_seq_ecg  = 0;
    exp_seq_tch  = 0;
    last_was_tch = 1'b1;
    rx_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++;
    if (ecg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ecg_ready: got %b, required 1", ecg_ready); end
    n_checks++;
    if (tch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tch_ready: got %b, required 1", tch_ready); end
    do_reset();
  endtask

  task automatic test_touch_basic();
    byte_q_t exp;
    rx_q.delete();
    exp = exp_tch(16'h0ABC);
    tch_valid = 1'b1;
    tch_data  = 16'h0ABC;
    @(posedge clk); #1;          // holder load edge
    tch_valid = 1'b0;
    n_checks++;
    if (tch_ready !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL touch_after_load: ready=%b tx_valid=%b, required 0 0", tch_ready, tx_valid);
    end
    @(posedge clk); #1;          // grant edge
    n_checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0 || tch_ready !== 1'b1) begin
      n_fail++; $display("FAIL touch_after_grant: busy=%b tx_valid=%b ready=%b, required 1 0 1", busy, tx_valid, tch_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp[0]) begin
      n_fail++; $display("FAIL touch_first_sync: valid=%b data=%h, required 1 %h", tx_valid, tx_data, exp[0]);
    end
    wait_bytes(exp.size());
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL touch_busy_after_csum: got %b, required 0", busy); end
    n_checks++;
    if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL touch_len: got %0d, required %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL touch_byte[%0d]: got %h, required %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_simultaneous();
    byte_q_t     exp;
    logic [47:0] d_e, d_3;
    logic [15:0] d_t;
    bit          first_ecg;
    rx_q.delete();
    d_e = rand48(); d_t = 16'($urandom); d_3 = rand48();
    first_ecg = last_was_tch;
    ecg_valid = 1'b1; ecg_data = d_e;
    tch_valid = 1'b1; tch_data = d_t;
    @(posedge clk); #1;
    ecg_valid = 1'b0; tch_valid = 1'b0;
    n_checks++;
    if (ecg_ready !== 1'b0 || tch_ready !== 1'b0) begin
      n_fail++; $display("FAIL simul_both_full: ecg_ready=%b tch_ready=%b, required 0 0", ecg_ready, tch_ready);
    end
    // The first winner reloads during its own packet, so both holders are
    // full again when it ends and the loser must go next.
    if (first_ecg) begin
      exp = exp_ecg(d_e);
      exp = cat(exp, exp_tch(d_t));
      exp = cat(exp, exp_ecg(d_3));
      send_ecg(d_3);
    end else begin
      exp = exp_tch(d_t);
      exp = cat(exp, exp_ecg(d_e));
      exp = cat(exp, exp_tch(d_3[15:0]));
      send_tch(d_3[15:0]);
    end
    wait_bytes(exp.size());
    wait_idle();
    n_checks++;
    if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL simul_len: got %0d, required %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL simul_byte[%0d]: got %h, required %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_ecg();
    byte_q_t     exp;
    logic [47:0] d2;
    rx_q.delete();
    d2  = rand48();
    exp = exp_ecg(48'h010203040506);
    exp = cat(exp, exp_ecg(d2));
    send_ecg(48'h010203040506);
    send_ecg(d2);
    wait_bytes(exp.size());
    wait_idle();
    n_checks++;
    if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL ecg_len: got %0d, required %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL ecg_byte[%0d]: got %h, required %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    byte_q_t     exp;
    logic [47:0] d;
    logic [7:0]  held;
    rx_q.delete();
    d   = rand48();
    exp = exp_ecg(d);
    send_ecg(d);
    wait_bytes(4);
    tx_ready = 1'b0;
    held = tx_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== held) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%h, required 1 %h", i, tx_valid, tx_data, held);
      end
    end
    tx_ready = 1'b1;
    wait_bytes(exp.size());
    wait_idle();
    n_checks++;
    if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL bp_len: got %0d, required %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_seq_wrap();
    byte_q_t     exp;
    logic [15:0] d;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      d   = 16'($urandom);
      exp = cat(exp, exp_tch(d));
      send_tch(d);
      if (k == 0) begin
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || tch_ready !== 1'b1) begin
          n_fail++; $display("FAIL wrap_ready_in_flight: busy=%b ready=%b, required 1 1", busy, tch_ready);
        end
      end
    end
    wait_bytes(exp.size());
    wait_idle();
    n_checks++;
    if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL wrap_len: got %0d, required %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_byte[%0d]: got %h, required %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t     exp;
    logic [15:0] d;
    rx_q.delete();
    send_ecg(rand48());
    send_tch(16'($urandom));
    wait_bytes(4);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b0 || ecg_ready !== 1'b1 || tch_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: tx_valid=%b ecg_ready=%b tch_ready=%b busy=%b, required 0 1 1 0",
                         tx_valid, ecg_ready, tch_ready, busy);
    end
    rst = 1'b0;
    exp_seq_ecg  = 0;
    exp_seq_tch  = 0;
    last_was_tch = 1'b1;
    rx_q.delete();
    d   = 16'($urandom);
    exp = exp_tch(d);
    send_tch(d);
    wait_bytes(exp.size());
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (rx_q.size() != exp.size() || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_len: got %0d bytes busy=%b, required %0d bytes busy=0", rx_q.size(), busy, exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL midreset_byte[%0d]: got %h, required %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [47:0] q_e[$];
    logic [15:0] q_t[$];
    byte_q_t     exp;
    int          total, idx;
    bit          done;
    logic [7:0]  hdr;
    bit          ok;
    rx_q.delete();
    done  = 1'b0;
    total = 12 * 9 + 15 * 5;
    fork
      begin
        fork
          begin
            logic [47:0] d;
            for (int k = 0; k < 12; k++) begin
              d = rand48();
              q_e.push_back(d);
              send_ecg(d);
              repeat ($urandom_range(0, 20)) @(posedge clk);
              #1;
            end
          end
          begin
            logic [15:0] d;
            for (int k = 0; k < 15; k++) begin
              d = 16'($urandom);
              q_t.push_back(d);
              send_tch(d);
              repeat ($urandom_range(0, 12)) @(posedge clk);
              #1;
            end
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          tx_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    tx_ready = 1'b1;
    wait_bytes(total);
    wait_idle();
    n_checks++;
    if (rx_q.size() != total) begin n_fail++; $display("FAIL rand_len: got %0d, required %0d", rx_q.size(), total); end
    idx = 0;
    while (idx + 1 < rx_q.size()) begin
      hdr = rx_q[idx + 1];
      if (hdr[7:4] == 4'hE && q_e.size() > 0) begin
        exp = exp_ecg(q_e.pop_front());
      end else if (hdr[7:4] == 4'h7 && q_t.size() > 0) begin
        exp = exp_tch(q_t.pop_front());
      end else begin
        n_checks++; n_fail++;
        $display("FAIL rand_hdr@%0d: got %h, required a pending ECG or touch header", idx, hdr);
        break;
      end
      ok = 1'b1;
      for (int i = 0; i < exp.size(); i++)
        if (idx + i >= rx_q.size() || rx_q[idx + i] !== exp[i]) ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL rand_pkt@%0d: got hdr %h, required packet starting %h %h", idx, hdr, exp[0], exp[1]);
      end
      idx += exp.size();
    end
    n_checks++;
    if (q_e.size() != 0 || q_t.size() != 0) begin
      n_fail++; $display("FAIL rand_undelivered: ecg=%0d tch=%0d left, required 0 0", q_e.size(), q_t.size());
    end
  endtask

  initial begin
    test_reset();
    test_touch_basic();
    test_simultaneous();
    test_ecg();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
